cg_enable_ctrl: RTL and testbench
=================================

Name: cg_enable_ctrl

Overview:
- Activity-driven controller that produces the `Enable` input of a `CG_MOD` clock-gate cell.
- Arbitrates wake requests from up to NUM_REQ consumers of the gated clock.
- Holds requesters off until a wake-up settling window has elapsed, and keeps the clock running for an idle hysteresis window before gating it off again.
- Sits in the ungated clock domain, directly driving one `CG_MOD` instance per gated region.

Parameters:
- NUM_REQ, 4, number of requester channels (1..16).
- WAKE_CYCLES, 2, settling cycles from `Enable` rising to `Ack` permitted (1..255).
- IDLE_CYCLES, 4, idle cycles with no request/force before `Enable` falls (0..255).
- CNT_W, 16, width of the saturating wake-event counter.

Ports:
- ClkIn  input  1  free-running (ungated) clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req  input  NUM_REQ  per-channel request for the gated clock; level, held until done.
- ForceOn  input  1  test/override: keeps clock enabled; generates no `Ack`.
- Enable  output  1  registered; drives `CG_MOD.Enable`.
- Ack  output  NUM_REQ  registered; `Ack[i]`=1 means gated clock is stable and granted to channel i.
- Active  output  1  registered; 1 while in state ON.
- WakeCount  output  CNT_W  registered; saturating count of OFF->WAKE transitions.

Behaviour:
- States: OFF, WAKE, ON, HOLD. Internal counters: WakeCnt (8b), IdleCnt (8b). AnyReq = |Req.
- Reset, sampled at any edge, including mid-operation:
  - next state OFF; Enable=0, Ack=0, Active=0, WakeCount=0, counters 0.
  - No glitch requirement beyond registered outputs.
- OFF:
  - AnyReq or ForceOn -> WAKE; Enable<=1; WakeCnt<=WAKE_CYCLES; WakeCount += 1, saturating at all-ones.
- WAKE:
  - WakeCnt decrements each edge. At an edge where WakeCnt==1 -> ON.
  - A WAKE is never aborted. If requests vanish during WAKE, the block still enters ON, then immediately proceeds to HOLD on the following edge.
- ON:
  - If !AnyReq && !ForceOn -> HOLD with IdleCnt<=IDLE_CYCLES.
  - If IDLE_CYCLES==0, go -> OFF directly and Enable<=0 on the same edge.
- HOLD:
  - AnyReq or ForceOn -> ON.
  - Else IdleCnt decrements; at an edge where IdleCnt==1 -> OFF and Enable<=0.
- Ack rule: every edge, Ack <= Req & {NUM_REQ{next_state==ON}}.
  - Ack rises on the same edge the state enters ON.
  - Ack[i] falls on the edge after Req[i] falls.
  - A new Req during ON or HOLD is acked on the next edge.
- Enable <= (next_state != OFF). Active <= (next_state == ON).
- Latency from OFF: Req asserted before edge k gives Enable=1 after edge k and Ack=1 after edge k+WAKE_CYCLES.
- Simultaneous events:
  - A Req rising on the same edge another Req falls keeps ON; no HOLD.
  - ForceOn alone holds ON with Ack=0.
  - Reset has priority over everything.

Decomposition:
- Shared package `cg_ctrl_pkg`: state encoding constants (OFF=2'd0, WAKE=2'd1, ON=2'd2, HOLD=2'd3) and counter width constant (8).
- One natural sub-module: `cg_down_counter` (load / decrement / is-one flag), instantiated twice for WakeCnt and IdleCnt.
- `CG_MOD` is instantiated by the parent, not inside this block.

Test Plan:
- Reset, then Req=4'b0001 at edge 1 -> Enable=1 after edge 1; Ack=4'b0001 after edge 3; WakeCount=1.
- Drop Req after Ack (params 2/4) -> Ack=0 next edge; Enable stays 1 for 4 idle edges, then 0; state OFF.
- During HOLD (idle edge 2), assert Req=4'b0100 -> ON and Ack=4'b0100 on the next edge; Enable never drops; WakeCount unchanged.
- Req=4'b0010 pulsed, dropped during WAKE -> ON for one cycle with Ack=0, then HOLD, then OFF after 4 idle edges.
- ForceOn=1 with Req=0 -> Enable=1, Active=1 after 3 edges, Ack=0; ForceOn=0 -> Enable falls 4 edges later.
- Assert Reset in ON with Req=4'b1111 -> next edge Enable=0, Ack=0, WakeCount=0; 65537 wake cycles -> WakeCount saturates at 16'hFFFF.

Source files
------------

// File: rtl/cg_ctrl_pkg.sv
// Shared types and constants for the clock-gate enable controller.
package cg_ctrl_pkg;

  // Controller state encoding
  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    ON   = 2'd2,
    HOLD = 2'd3
  } cgState_e;

  // Width of the internal settling / idle down-counters
  localparam int unsigned CG_CNT_W = 8;

endpackage : cg_ctrl_pkg

// File: rtl/cg_down_counter.sv
// Loadable down-counter with an "equals one" flag; stops at zero.
module cg_down_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         dec,
  output logic         isOne
);

  logic [W-1:0] count;

  // Load has priority over decrement; decrement never wraps below zero
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign isOne = (count == W'(1));

endmodule : cg_down_counter

// File: rtl/cg_enable_ctrl.sv
// Activity-driven controller producing the Enable input of a CG_MOD clock gate.
module cg_enable_ctrl
  import cg_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned IDLE_CYCLES = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               ClkIn,
  input  logic               Reset,
  input  logic [NUM_REQ-1:0] Req,
  input  logic               ForceOn,
  output logic               Enable,
  output logic [NUM_REQ-1:0] Ack,
  output logic               Active,
  output logic [CNT_W-1:0]   WakeCount
);

  localparam bit IdleBypass = (IDLE_CYCLES == 0);

  cgState_e state;
  cgState_e nextState;
  logic     keepOn;
  logic     wakeLoad;
  logic     wakeIsOne;
  logic     idleLoad;
  logic     idleDec;
  logic     idleIsOne;

  assign keepOn   = (|Req) || ForceOn;
  assign wakeLoad = (state == OFF) && keepOn;
  assign idleLoad = (state == ON) && !keepOn;
  assign idleDec  = (state == HOLD) && !keepOn;

  cg_down_counter #(
    .W(CG_CNT_W)
  ) uWakeCnt (
    .clk     (ClkIn),
    .reset   (Reset),
    .load    (wakeLoad),
    .loadVal (CG_CNT_W'(WAKE_CYCLES)),
    .dec     (state == WAKE),
    .isOne   (wakeIsOne)
  );

  cg_down_counter #(
    .W(CG_CNT_W)
  ) uIdleCnt (
    .clk     (ClkIn),
    .reset   (Reset),
    .load    (idleLoad),
    .loadVal (CG_CNT_W'(IDLE_CYCLES)),
    .dec     (idleDec),
    .isOne   (idleIsOne)
  );

  // Next-state selection; a wake, once started, always runs to ON
  always_comb begin
    nextState = state;
    unique case (state)
      OFF:     nextState = keepOn ? WAKE : OFF;
      WAKE:    nextState = wakeIsOne ? ON : WAKE;
      ON: begin
        if (!keepOn) begin
          nextState = IdleBypass ? OFF : HOLD;
        end
      end
      HOLD: begin
        if (keepOn) begin
          nextState = ON;
        end else if (idleIsOne) begin
          nextState = OFF;
        end
      end
      default: nextState = OFF;
    endcase
  end

  // State register and registered outputs, all derived from the next state
  always_ff @(posedge ClkIn) begin
    if (Reset) begin
      state     <= OFF;
      Enable    <= 1'b0;
      Active    <= 1'b0;
      Ack       <= '0;
      WakeCount <= '0;
    end else begin
      state  <= nextState;
      Enable <= (nextState != OFF);
      Active <= (nextState == ON);
      Ack    <= Req & {NUM_REQ{nextState == ON}};
      if (wakeLoad && (WakeCount != '1)) begin
        WakeCount <= WakeCount + CNT_W'(1);
      end
    end
  end

endmodule : cg_enable_ctrl

// File: tb/tb_cg_enable_ctrl.sv
// Self-checking bench for cg_enable_ctrl: directed scenarios plus random traffic
// compared against an idle-streak based reference model.
module tb_cg_enable_ctrl;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WAKEC = 2;
  localparam int unsigned IDLEC = 4;
  localparam int unsigned TB_CNT_W = 8;
  localparam int unsigned WC_MAX = (1 << TB_CNT_W) - 1;

  logic                ClkIn = 1'b0;
  logic                Reset;
  logic [NREQ-1:0]     Req;
  logic                ForceOn;
  logic                Enable;
  logic [NREQ-1:0]     Ack;
  logic                Active;
  logic [TB_CNT_W-1:0] WakeCount;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: enabled flag, remaining settle edges, consecutive idle edges
  bit              mEn;
  int unsigned     mWakeLeft;
  int unsigned     mIdle;
  int unsigned     mWc;
  logic [NREQ-1:0] mAck;
  bit              mOn;

  cg_enable_ctrl #(
    .NUM_REQ     (NREQ),
    .WAKE_CYCLES (WAKEC),
    .IDLE_CYCLES (IDLEC),
    .CNT_W       (TB_CNT_W)
  ) dut (
    .ClkIn     (ClkIn),
    .Reset     (Reset),
    .Req       (Req),
    .ForceOn   (ForceOn),
    .Enable    (Enable),
    .Ack       (Ack),
    .Active    (Active),
    .WakeCount (WakeCount)
  );

  always #5 ClkIn = ~ClkIn;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic modelStep(input bit rst, input logic [NREQ-1:0] req, input bit frc);
    bit want;
    want = (|req) || frc;
    if (rst) begin
      mEn = 0; mWakeLeft = 0; mIdle = 0; mWc = 0;
    end else if (!mEn) begin
      if (want) begin
        mEn = 1;
        mWakeLeft = WAKEC;
        if (mWc < WC_MAX) mWc++;
      end
    end else if (mWakeLeft > 0) begin
      mWakeLeft--;
    end else if (want) begin
      mIdle = 0;
    end else begin
      mIdle++;
      if (mIdle > IDLEC) begin
        mEn = 0;
        mIdle = 0;
      end
    end
    mOn  = mEn && (mWakeLeft == 0) && (mIdle == 0);
    mAck = (mOn && !rst) ? req : '0;
  endtask

  // One clock edge: advance the model with the inputs seen at the edge, then compare
  task automatic step();
    @(posedge ClkIn);
    modelStep(Reset, Req, ForceOn);
    #1;
    checkVal("enable", Enable, mEn);
    checkVal("active", Active, mOn);
    checkVal("ack", Ack, mAck);
    checkVal("wakecount", WakeCount, mWc);
  endtask

  task automatic steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  initial begin
    int unsigned wcSave;
    Reset = 1'b1; Req = '0; ForceOn = 1'b0;
    mEn = 0; mWakeLeft = 0; mIdle = 0; mWc = 0; mAck = '0; mOn = 0;
    step();
    checkVal("rst_enable", Enable, 0);
    checkVal("rst_wc", WakeCount, 0);
    Reset = 1'b0;

    // Wake latency from OFF
    Req = 4'b0001;
    step();
    checkVal("lat_enable", Enable, 1);
    checkVal("lat_ack_early", Ack, 0);
    steps(2);
    checkVal("lat_ack", Ack, 4'b0001);
    checkVal("lat_wc", WakeCount, 1);

    // Idle hysteresis
    Req = '0;
    step();
    checkVal("drop_ack", Ack, 0);
    steps(3);
    checkVal("hold_enable", Enable, 1);
    step();
    checkVal("off_enable", Enable, 0);

    // Re-request during HOLD returns to ON without a new wake
    Req = 4'b0001;
    steps(3);
    wcSave = WakeCount;
    Req = '0;
    steps(2);
    Req = 4'b0100;
    step();
    checkVal("hold_reacq_active", Active, 1);
    checkVal("hold_reacq_ack", Ack, 4'b0100);
    checkVal("hold_reacq_wc", WakeCount, wcSave);
    Req = '0;
    steps(6);
    checkVal("idle_off", Enable, 0);

    // Request vanishing during WAKE
    Req = 4'b0010;
    step();
    Req = '0;
    steps(2);
    checkVal("wakedrop_active", Active, 1);
    checkVal("wakedrop_ack", Ack, 0);
    step();
    checkVal("wakedrop_hold", Active, 0);
    steps(5);

    // ForceOn alone
    ForceOn = 1'b1;
    steps(3);
    checkVal("force_active", Active, 1);
    checkVal("force_ack", Ack, 0);
    steps(2);
    ForceOn = 1'b0;
    steps(6);

    // Reset while ON
    Req = 4'b1111;
    steps(4);
    Reset = 1'b1;
    step();
    checkVal("midrst_enable", Enable, 0);
    checkVal("midrst_ack", Ack, 0);
    checkVal("midrst_wc", WakeCount, 0);
    Reset = 1'b0;
    Req = '0;
    steps(2);

    // Random traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      if ($urandom_range(3, 0) == 0) Req[$urandom_range(NREQ - 1, 0)] ^= 1'b1;
      if ($urandom_range(31, 0) == 0) ForceOn = ~ForceOn;
      if ($urandom_range(15, 0) == 0) Req = '0;
      Reset = ($urandom_range(199, 0) == 0);
      step();
    end
    Reset = 1'b1; Req = '0; ForceOn = 1'b0;
    step();
    Reset = 1'b0;

    // WakeCount saturation
    for (int unsigned i = 0; i < WC_MAX + 5; i++) begin
      Req = 4'b1000;
      step();
      Req = '0;
      steps(9);
    end
    checkVal("wc_saturate", WakeCount, WC_MAX);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_cg_enable_ctrl
